// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg
// Shared types and helpers for the PLL lock sequencer.
//   state_t  : sequencer state encoding (also exported on the STATE port)
//   retry_w(): width needed to hold a retry count of 0..max_retries
// ---------------------------------------------------------------------------
package pll_seq_pkg;

    typedef enum logic [2:0] {
        HOLD_RESET = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        RUN        = 3'd3,
        FAULT      = 3'd4
    } state_t;

    function automatic int unsigned retry_w(input int unsigned max_retries);
        if (max_retries < 1)
            return 1;
        return $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// 1-bit, 2-stage synchroniser for a level signal from another clock domain.
//   clk : destination clock
//   rst : synchronous, active-high; clears both stages
//   d   : asynchronous input
//   q   : synchronised output, 2 clk cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
// Drives the iCE40 PLL RESET/BYPASS pins, qualifies its asynchronous LOCK
// output and releases the downstream system reset only after a stable lock.
// Failed lock attempts are retried; after MAX_RETRIES failures the sequencer
// parks in FAULT until RESET or RELOCK_REQ.
//   CLK         : 100 MHz reference clock (also the PLL reference)
//   RESET       : synchronous, active-high
//   PLL_LOCK    : PLL lock indicator, asynchronous to CLK
//   RELOCK_REQ  : single-cycle pulse, restarts the lock sequence
//   PLL_RESETB  : PLL reset, active-low
//   PLL_BYPASS  : PLL bypass select
//   SYS_RESET   : reset request for the PLL output clock domain
//   READY       : high only in RUN
//   FAULT       : high only in FAULT
//   RETRY_COUNT : failed attempts in the current sequence
//   STATE       : current state encoding, for debug
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int unsigned RESET_CYCLES    = 100,
    parameter int unsigned LOCK_TIMEOUT    = 10000,
    parameter int unsigned STABLE_CYCLES   = 1024,
    parameter int unsigned LOSS_FILTER     = 4,
    parameter int unsigned MAX_RETRIES     = 3,
    parameter bit          BYPASS_ON_FAULT = 1'b1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PLL_LOCK,
    input  logic       RELOCK_REQ,
    output logic       PLL_RESETB,
    output logic       PLL_BYPASS,
    output logic       SYS_RESET,
    output logic       READY,
    output logic       FAULT,
    output logic [1:0] RETRY_COUNT,
    output logic [2:0] STATE
);

    import pll_seq_pkg::*;

    localparam int unsigned RETRY_W = retry_w(MAX_RETRIES);

    // Terminal counts: each state leaves on the cycle its counter hits these.
    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOSS_LAST    = CNT_W'(LOSS_FILTER - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_d;
    logic               lock_s;
    logic               fail;

    sync_2ff u_lock_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (PLL_LOCK),
        .q   (lock_s)
    );

    // Next-state logic. One shared counter serves as hold timer, lock
    // timeout, stability count and (in RUN) the consecutive-low filter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        fail    = 1'b0;

        if (RELOCK_REQ) begin
            state_d = HOLD_RESET;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                HOLD_RESET: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        fail = 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        fail = 1'b1;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    if (lock_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOSS_LAST) begin
                        // Lock lost after a good run: fresh sequence, not a retry.
                        state_d = HOLD_RESET;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                pll_seq_pkg::FAULT: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = HOLD_RESET;
                    cnt_d   = '0;
                end
            endcase

            if (fail) begin
                cnt_d = '0;
                if (retry_q >= RETRY_MAX) begin
                    state_d = pll_seq_pkg::FAULT;
                end else begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = HOLD_RESET;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they move on the same
    // edge as STATE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= HOLD_RESET;
            cnt_q      <= '0;
            retry_q    <= '0;
            PLL_RESETB <= 1'b0;
            PLL_BYPASS <= 1'b0;
            SYS_RESET  <= 1'b1;
            READY      <= 1'b0;
            FAULT      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            PLL_RESETB <= (state_d == WAIT_LOCK) || (state_d == STABLE) ||
                          (state_d == RUN);
            PLL_BYPASS <= BYPASS_ON_FAULT && (state_d == pll_seq_pkg::FAULT);
            SYS_RESET  <= (state_d != RUN);
            READY      <= (state_d == RUN);
            FAULT      <= (state_d == pll_seq_pkg::FAULT);
        end
    end

    assign STATE       = state_q;
    assign RETRY_COUNT = 2'(retry_q);

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Sequences the 100 MHz -> 48.96 MHz iCE40 PLL wrapper: drives its active-low RESET and BYPASS inputs, qualifies its asynchronous LOCK output, and issues the system reset for the 48.96 MHz domain only after a stable lock. Runs on the 100 MHz reference clock, sits beside the PLL instance at top level, retries failed lock attempts and declares a fault after a bounded number of retries.

Parameters:
RESET_CYCLES, 100, cycles PLL_RESETB is held low per attempt (1 us).
LOCK_TIMEOUT, 10000, max cycles in WAIT_LOCK before the attempt fails (100 us).
STABLE_CYCLES, 1024, consecutive synchronised-lock-high cycles required before RUN.
LOSS_FILTER, 4, consecutive synchronised-lock-low cycles in RUN treated as lock loss.
MAX_RETRIES, 3, failed attempts tolerated before FAULT.
BYPASS_ON_FAULT, 1, drive PLL_BYPASS high while in FAULT.
CNT_W, 16, width of the shared cycle counter; must hold max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
CLK  in  1  100 MHz reference clock; the same net feeds the PLL REFERENCECLK.
RESET  in  1  synchronous, active-high.
PLL_LOCK  in  1  PLL LOCK output, asynchronous to CLK.
RELOCK_REQ  in  1  single-cycle pulse; forces a fresh lock sequence.
PLL_RESETB  out  1  to PLL RESET pin, active-low.
PLL_BYPASS  out  1  to PLL BYPASS pin.
SYS_RESET  out  1  active-high reset request for the 48.96 MHz domain; re-synchronised there.
READY  out  1  high only in RUN.
FAULT  out  1  high only in FAULT.
RETRY_COUNT  out  2  failed attempts in the current sequence.
STATE  out  3  current state encoding, for debug.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RESET.
- Lock synchronisation: PLL_LOCK passes through a 2-flop synchroniser to produce lock_s. Every lock-dependent decision uses lock_s, which adds 2 cycles of latency.
- Registered outputs: all outputs are registered and decoded from the next state, so they change on the same edge as STATE.
- Reset values: STATE=HOLD_RESET, counter=0, PLL_RESETB=0, PLL_BYPASS=0, SYS_RESET=1, READY=0, FAULT=0, RETRY_COUNT=0, synchroniser flops=0.
- HOLD_RESET (0): PLL_RESETB=0, SYS_RESET=1. Stays exactly RESET_CYCLES cycles, then goes to WAIT_LOCK with the counter cleared.
- WAIT_LOCK (1): PLL_RESETB=1.
  - lock_s=1 -> STABLE with the counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s=0 -> failure.
- STABLE (2):
  - lock_s=0 on any cycle -> failure.
  - STABLE_CYCLES consecutive high cycles -> RUN.
- RUN (3): SYS_RESET=0, READY=1, RETRY_COUNT cleared on entry. Counts consecutive lock_s=0 cycles; a single high cycle resets that count.
  - LOSS_FILTER consecutive low cycles -> HOLD_RESET with RETRY_COUNT=0. This is a new sequence, not a retry.
  - SYS_RESET rises on the same edge as the transition.
- Failure handling:
  - RETRY_COUNT == MAX_RETRIES -> FAULT.
  - Otherwise RETRY_COUNT++ and go to HOLD_RESET.
  - RETRY_COUNT saturates at MAX_RETRIES and never wraps.
- FAULT (4): PLL_RESETB=0, PLL_BYPASS=BYPASS_ON_FAULT, SYS_RESET=1, FAULT=1. Exits only via RESET or RELOCK_REQ.
- RELOCK_REQ in any state: next state is HOLD_RESET with the counter and RETRY_COUNT cleared. In HOLD_RESET this restarts the hold count.
- Priority: RESET > RELOCK_REQ > failure/timeout > normal transitions.
- Unused encodings 5-7 go to HOLD_RESET on the next edge.
- Reset mid-operation: RESET in any state returns all outputs to their reset values on the next edge.

Decomposition:
- Package pll_seq_pkg holds the state enum (HOLD_RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4) and a function computing RETRY_W from MAX_RETRIES.
- One sub-module, sync_2ff, is the 1-bit, 2-stage synchroniser, reusable elsewhere in the design.

Test Plan:
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, LOSS_FILTER=3, MAX_RETRIES=2.
1. Release RESET; PLL_LOCK rises 6 cycles after PLL_RESETB rises -> PLL_RESETB low for exactly 4 cycles; READY and SYS_RESET=0 exactly 2+8 cycles after the PLL_LOCK edge; RETRY_COUNT=0.
2. PLL_LOCK held 0 -> 3 attempts of 4 low + 20 wait cycles each; RETRY_COUNT steps 0,1,2; FAULT=1, PLL_BYPASS=1, PLL_RESETB=0 held indefinitely.
3. In RUN, PLL_LOCK low for 2 cycles -> stays in RUN; low for 3 cycles -> SYS_RESET=1 on the 3rd synchronised-low edge; HOLD_RESET; RETRY_COUNT=0.
4. In STABLE, PLL_LOCK glitches low for 1 cycle at count 5 -> failure; RETRY_COUNT=1; PLL_RESETB low for 4 cycles.
5. In FAULT, pulse RELOCK_REQ -> FAULT=0, RETRY_COUNT=0, HOLD_RESET next edge; RELOCK_REQ coincident with a WAIT_LOCK timeout -> RETRY_COUNT=0, not incremented.
6. RESET asserted in RUN together with RELOCK_REQ -> all outputs return to reset values next edge; STATE=0.
